// File: rtl/pmp_pkg.sv
// Shared constants and types for the PMP access checker.
//   - A-field encodings of a pmpcfg byte
//   - bit positions inside a pmpcfg byte
//   - privilege level encodings
//   - checker FSM state encoding
//   - request/response bundles held by the checker
package pmp_pkg;

   typedef enum logic [1:0] {
      PMP_OFF   = 2'd0,
      PMP_TOR   = 2'd1,
      PMP_NA4   = 2'd2,
      PMP_NAPOT = 2'd3
   } pmp_a_e;

   localparam int unsigned CFG_R    = 0;
   localparam int unsigned CFG_W    = 1;
   localparam int unsigned CFG_X    = 2;
   localparam int unsigned CFG_A_LO = 3;
   localparam int unsigned CFG_A_HI = 4;
   localparam int unsigned CFG_L    = 7;

   typedef enum logic [1:0] {
      PRIV_U = 2'd0,
      PRIV_S = 2'd1,
      PRIV_M = 2'd3
   } priv_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WALK = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef struct packed {
      logic [31:0] waddr;
      logic [2:0]  access;
      logic [1:0]  priv;
   } pmp_req_t;

   typedef struct packed {
      logic       allow;
      logic       match;
      logic [3:0] idx;
   } pmp_resp_t;

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match for a single PMP entry.
//   cfg   : pmpcfg byte of the entry (only the A field matters here)
//   p     : pmpaddr of the entry (word address)
//   lo    : pmpaddr of the previous entry, 0 for entry 0 (TOR lower bound)
//   addr  : word address of the access
//   match : entry covers addr
module pmp_entry_match
   import pmp_pkg::*;
(
   input  logic [7:0]  cfg,
   input  logic [31:0] p,
   input  logic [31:0] lo,
   input  logic [31:0] addr,
   output logic        match
);

   logic [31:0] napot_mask;
   logic        unused_cfg;

   assign unused_cfg = ^{cfg[7:5], cfg[2:0]};

   // Trailing ones of p plus the first zero span the region; p+1 wraps so
   // an all-ones p yields an all-ones mask and matches everything.
   assign napot_mask = p ^ (p + 32'd1);

   always_comb begin
      match = 1'b0;
      case (pmp_a_e'(cfg[CFG_A_HI:CFG_A_LO]))
         PMP_TOR:   match = (lo < p) && (addr >= lo) && (addr < p);
         PMP_NA4:   match = (addr == p);
         PMP_NAPOT: match = ((addr ^ p) & ~napot_mask) == 32'd0;
         default:   match = 1'b0;
      endcase
   end

endmodule

// File: rtl/pmp_access_checker.sv
// Sequential PMP permission checker: walks one entry per cycle from a
// snapshot of the CSR pmpcfg/pmpaddr vectors and stops on the first match.
//   clk_i, rst_i                 : clock, async active-high reset
//   pmpcfg_i, pmpaddr_i          : 16 cfg bytes / 16 word addresses from CSRs
//   req_valid_i/req_ready_o      : request handshake (ready only in IDLE)
//   req_addr_i/access_i/priv_i   : byte address, needed {X,W,R}, privilege
//   resp_valid_o/resp_ready_i    : response handshake
//   resp_allow_o/match_o/idx_o   : decision, any-match flag, matching index
module pmp_access_checker
   import pmp_pkg::*;
#(
   parameter int unsigned NrPMPEntries = 8,
   parameter int unsigned PLEN         = 34
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [127:0]     pmpcfg_i,
   input  logic [511:0]     pmpaddr_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [PLEN-1:0]  req_addr_i,
   input  logic [2:0]       req_access_i,
   input  logic [1:0]       req_priv_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic             resp_allow_o,
   output logic             resp_match_o,
   output logic [3:0]       resp_idx_o
);

   localparam logic [3:0] LastIdx = (NrPMPEntries == 0) ? 4'd0 : 4'(NrPMPEntries - 1);

   logic [1:0]   state_q;
   pmp_req_t     req_q;
   pmp_resp_t    resp_q;
   logic [127:0] cfg_q;
   logic [511:0] addr_q;
   logic [3:0]   idx_q;

   logic [3:0]   idx_prev;
   logic [7:0]   cur_cfg;
   logic [31:0]  cur_p;
   logic [31:0]  cur_lo;
   logic         hit;
   logic         hit_allow;
   logic         is_m;
   logic         unused_addr;

   assign unused_addr = ^req_addr_i[1:0];

   // Only the snapshot is ever looked at, so CSR writes during a walk
   // cannot change the answer of the transaction in flight.
   assign idx_prev = idx_q - 4'd1;
   assign cur_cfg  = cfg_q[{idx_q, 3'b000} +: 8];
   assign cur_p    = addr_q[{idx_q, 5'b00000} +: 32];
   assign cur_lo   = (idx_q == 4'd0) ? 32'd0 : addr_q[{idx_prev, 5'b00000} +: 32];

   pmp_entry_match u_match (
      .cfg   (cur_cfg),
      .p     (cur_p),
      .lo    (cur_lo),
      .addr  (req_q.waddr),
      .match (hit)
   );

   assign is_m = (req_q.priv == PRIV_M);

   // Unlocked entries do not constrain M-mode; otherwise every requested
   // permission bit must be granted by the entry.
   assign hit_allow = (is_m && !cur_cfg[CFG_L]) ||
                      ((req_q.access & ~{cur_cfg[CFG_X], cur_cfg[CFG_W], cur_cfg[CFG_R]}) == 3'b000);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         resp_q  <= '0;
         cfg_q   <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i) begin
                  req_q.waddr  <= 32'(req_addr_i[PLEN-1:2]);
                  req_q.access <= req_access_i;
                  req_q.priv   <= req_priv_i;
                  cfg_q        <= pmpcfg_i;
                  addr_q       <= pmpaddr_i;
                  idx_q        <= 4'd0;
                  if (NrPMPEntries == 0) begin
                     resp_q  <= '{allow: (req_priv_i == PRIV_M), match: 1'b0, idx: 4'd0};
                     state_q <= ST_RESP;
                  end else begin
                     state_q <= ST_WALK;
                  end
               end
            end
            ST_WALK: begin
               if (hit) begin
                  resp_q  <= '{allow: hit_allow, match: 1'b1, idx: idx_q};
                  state_q <= ST_RESP;
               end else if (idx_q == LastIdx) begin
                  resp_q  <= '{allow: is_m, match: 1'b0, idx: 4'd0};
                  state_q <= ST_RESP;
               end else begin
                  idx_q <= idx_q + 4'd1;
               end
            end
            ST_RESP: begin
               if (resp_ready_i) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = (state_q == ST_RESP);
   assign resp_allow_o = resp_q.allow;
   assign resp_match_o = resp_q.match;
   assign resp_idx_o   = resp_q.idx;

endmodule

// File: tb/tb_pmp_access_checker.sv
// Directed + randomized bench for pmp_access_checker (NrPMPEntries = 8).
module tb_pmp_access_checker;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] pmpcfg;
   logic [511:0] pmpaddr;
   logic         req_valid, req_ready;
   logic [33:0]  req_addr;
   logic [2:0]   req_access;
   logic [1:0]   req_priv;
   logic         resp_valid, resp_ready, resp_allow, resp_match;
   logic [3:0]   resp_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pmp_access_checker #(.NrPMPEntries(N), .PLEN(34)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pmpcfg_i     (pmpcfg),
      .pmpaddr_i    (pmpaddr),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_access_i (req_access),
      .req_priv_i   (req_priv),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_allow_o (resp_allow),
      .resp_match_o (resp_match),
      .resp_idx_o   (resp_idx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: regions computed as [base, base+size) ranges in 64-bit
   // arithmetic, first matching entry wins.
   function automatic void model(input logic [127:0] cf, input logic [511:0] ad,
                                 input logic [31:0] a, input logic [2:0] acc, input logic [1:0] pv,
                                 output logic m, output logic [3:0] ix, output logic al, output int lat);
      m = 1'b0; ix = 4'd0; al = (pv == 2'd3); lat = N + 1;
      for (int i = 0; i < N; i++) begin
         logic [7:0] c;
         longint unsigned p, lo, x, size, base;
         int t;
         bit hit;
         c = cf[i*8 +: 8];
         p = 64'(ad[i*32 +: 32]);
         lo = (i == 0) ? 64'd0 : 64'(ad[(i-1)*32 +: 32]);
         x = 64'(a);
         hit = 1'b0;
         case (c[4:3])
            2'd1: hit = (x >= lo) && (x < p);
            2'd2: hit = (x == p);
            2'd3: begin
               t = 0;
               while (t < 32 && p[t]) t++;
               size = 64'd1 << (t + 1);
               base = (p / size) * size;
               hit = (x >= base) && (x < base + size);
            end
            default: hit = 1'b0;
         endcase
         if (hit) begin
            m = 1'b1; ix = 4'(i); lat = i + 2;
            al = (pv == 2'd3 && !c[7]) || ((acc & ~c[2:0]) == 3'b000);
            return;
         end
      end
   endfunction

   task automatic run_req(input string tag, input logic [33:0] a, input logic [2:0] acc,
                          input logic [1:0] pv, input bit clobber, input int hold,
                          output logic o_allow, output logic o_match, output logic [3:0] o_idx,
                          output int o_lat);
      logic em, ea;
      logic [3:0] ei;
      int el;
      model(pmpcfg, pmpaddr, a[33:2], acc, pv, em, ei, ea, el);
      @(negedge clk);
      chk({tag, ".req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1; req_addr = a; req_access = acc; req_priv = pv;
      @(negedge clk);
      req_valid = 1'b0;
      if (clobber) pmpcfg = '0;
      o_lat = 1;
      while (!resp_valid && o_lat < 40) begin
         @(negedge clk);
         o_lat++;
      end
      o_allow = resp_allow; o_match = resp_match; o_idx = resp_idx;
      chk({tag, ".latency"}, 64'(o_lat), 64'(el));
      chk({tag, ".allow"}, 64'(resp_allow), 64'(ea));
      chk({tag, ".match"}, 64'(resp_match), 64'(em));
      chk({tag, ".idx"}, 64'(resp_idx), 64'(ei));
      repeat (hold) begin
         @(negedge clk);
         chk({tag, ".hold"}, {resp_valid, req_ready, resp_allow, resp_match, resp_idx},
             {1'b1, 1'b0, ea, em, ei});
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({tag, ".post_hs"}, {resp_valid, req_ready}, {1'b0, 1'b1});
   endtask

   task automatic set_entry(input int i, input logic [7:0] c, input logic [31:0] p);
      pmpcfg[i*8 +: 8] = c;
      pmpaddr[i*32 +: 32] = p;
   endtask

   task automatic tor_setup();
      pmpcfg = '0; pmpaddr = '0;
      set_entry(0, 8'h00, 32'h2000_0000);
      set_entry(1, 8'h0B, 32'h2000_0400);
   endtask

   initial begin
      logic al, ma;
      logic [3:0] ix;
      int lat;
      bit seen;

      rst = 1'b1; pmpcfg = '0; pmpaddr = '0; req_valid = 1'b0; req_addr = '0;
      req_access = '0; req_priv = '0; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset.outputs", {req_ready, resp_valid, resp_allow, resp_match, resp_idx}, 8'b1000_0000);
      rst = 1'b0;

      // NAPOT 4 KB at 0x8000_0000, R|X
      set_entry(0, 8'h1D, 32'h2000_01FF);
      run_req("napot_rd", 34'h0_8000_0010, 3'b001, 2'd0, 1'b0, 0, al, ma, ix, lat);
      chk("napot_rd.const", {al, ma, ix, 8'(lat)}, {1'b1, 1'b1, 4'd0, 8'd2});
      run_req("napot_wr", 34'h0_8000_0010, 3'b010, 2'd0, 1'b0, 0, al, ma, ix, lat);
      chk("napot_wr.const", {al, ma}, 2'b01);

      // TOR [0x8000_0000, 0x8000_1000), R|W
      tor_setup();
      run_req("tor_in", 34'h0_8000_0FFC, 3'b010, 2'd0, 1'b0, 0, al, ma, ix, lat);
      chk("tor_in.const", {al, ma, ix, 8'(lat)}, {1'b1, 1'b1, 4'd1, 8'd3});
      run_req("tor_out", 34'h0_8000_1000, 3'b010, 2'd0, 1'b0, 0, al, ma, ix, lat);
      chk("tor_out.const", {al, ma, 8'(lat)}, {1'b0, 1'b0, 8'd9});

      // CSR change after acceptance and response backpressure
      run_req("snap", 34'h0_8000_0FFC, 3'b010, 2'd0, 1'b1, 5, al, ma, ix, lat);
      chk("snap.const", {al, ma, ix}, {1'b1, 1'b1, 4'd1});

      // Lock semantics for M-mode
      pmpcfg = '0; pmpaddr = '0;
      set_entry(0, 8'h99, 32'hFFFF_FFFF);
      run_req("lock_m", 34'h0_1234_5678, 3'b010, 2'd3, 1'b0, 0, al, ma, ix, lat);
      chk("lock_m.const", {al, ma}, 2'b01);
      set_entry(0, 8'h19, 32'hFFFF_FFFF);
      run_req("unlock_m", 34'h0_1234_5678, 3'b010, 2'd3, 1'b0, 0, al, ma, ix, lat);
      chk("unlock_m.const", {al, ma}, 2'b11);
      pmpcfg = '0;
      run_req("nomatch_m", 34'h0_1234_5678, 3'b010, 2'd3, 1'b0, 0, al, ma, ix, lat);
      chk("nomatch_m.const", {al, ma, 8'(lat)}, {1'b1, 1'b0, 8'd9});

      // Entry beyond NrPMPEntries must stay inert
      pmpcfg = '0; pmpaddr = '0;
      set_entry(8, 8'h1F, 32'hFFFF_FFFF);
      run_req("inactive", 34'h0_0000_1000, 3'b001, 2'd0, 1'b0, 0, al, ma, ix, lat);
      chk("inactive.const", {al, ma}, 2'b00);

      // Reset in the middle of a walk
      tor_setup();
      run_req("pre_rst", 34'h0_8000_0FFC, 3'b010, 2'd0, 1'b0, 0, al, ma, ix, lat);
      pmpcfg = '0;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 34'h0_0000_1000; req_access = 3'b001; req_priv = 2'd0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_walk.outputs", {req_ready, resp_valid, resp_allow, resp_match, resp_idx}, 8'b1000_0000);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      chk("rst_walk.no_resp", 64'(seen), 64'd0);
      chk("rst_walk.ready", 64'(req_ready), 64'd1);
      tor_setup();
      run_req("post_rst", 34'h0_8000_0FFC, 3'b010, 2'd0, 1'b0, 0, al, ma, ix, lat);
      chk("post_rst.const", {al, ma, ix, 8'(lat)}, {1'b1, 1'b1, 4'd1, 8'd3});

      // Randomized configurations against the reference model
      for (int it = 0; it < 60; it++) begin
         logic [31:0] w;
         logic [1:0] pv;
         for (int i = 0; i < 16; i++) begin
            logic [31:0] p;
            case ($urandom_range(0, 3))
               0: p = 32'($urandom_range(0, 64));
               1: p = 32'($urandom_range(0, 15) * 8) | 32'((1 << $urandom_range(0, 2)) - 1);
               2: p = 32'hFFFF_FFFF;
               default: p = $urandom;
            endcase
            set_entry(i, 8'($urandom), p);
         end
         w = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 130));
         case ($urandom_range(0, 2))
            0: pv = 2'd0;
            1: pv = 2'd1;
            default: pv = 2'd3;
         endcase
         run_req("rand", {w, 2'($urandom)}, 3'($urandom), pv, 1'b0,
                 $urandom_range(0, 2), al, ma, ix, lat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pmp_access_checker.md
Name: pmp_access_checker

Overview:
- Sequential PMP checker. It reads the pmpcfg/pmpaddr vectors exported by the CSR register file and answers per-access permission queries.
- One entry is evaluated per cycle, in priority order (index 0 first). The walk stops early on the first match.
- Requests and responses use valid/ready handshakes. It sits between the LSU/fetch request path and the CSR block.

Parameters:
- NrPMPEntries, 8, number of active entries (0..16); entries at index >= NrPMPEntries are never evaluated.
- PLEN, 34, physical address width; word address is addr[PLEN-1:2] (32 bits).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- pmpcfg_i  input  128  16x8-bit cfg; entry i = [i*8+:8]; bits R=0, W=1, X=2, A=[4:3] (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), L=7
- pmpaddr_i  input  512  16x32-bit word addresses; entry i = [i*32+:32]
- req_valid_i  input  1  request valid
- req_ready_o  output  1  high only in IDLE
- req_addr_i  input  34  byte address; bits [1:0] ignored
- req_access_i  input  3  required permissions {X,W,R}; all set bits required
- req_priv_i  input  2  privilege (3 = M, 1 = S, 0 = U)
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response accepted
- resp_allow_o  output  1  access permitted
- resp_match_o  output  1  some entry matched
- resp_idx_o  output  4  index of matching entry (0 if no match)

Behaviour:
- Reset (async, rst_i=1): state IDLE; resp_valid_o=0, resp_allow_o=0, resp_match_o=0, resp_idx_o=0; req_ready_o=1 once in IDLE. Reset mid-walk or mid-response discards the transaction.
- FSM IDLE -> WALK -> RESP -> IDLE.
  - IDLE: on req_valid_i & req_ready_o, capture addr[33:2], access, priv, and snapshot pmpcfg_i/pmpaddr_i. Set idx=0 and go to WALK. If NrPMPEntries==0, go directly to RESP with no match.
  - WALK: evaluate only the snapshot entry idx; later changes on pmpcfg_i/pmpaddr_i are ignored.
    - On match: register match=1, idx, and the decision; go to RESP.
    - Else if idx==NrPMPEntries-1: register match=0; go to RESP.
    - Else: idx+1.
  - RESP: resp_valid_o=1 with stable outputs until resp_ready_i. Then go to IDLE; resp_valid_o drops the next cycle. No back-to-back acceptance, so req_ready_o returns the cycle after the handshake.
- Latency: acceptance edge = cycle 0. Match at entry k gives resp_valid_o in cycle k+2. No match gives resp_valid_o in cycle NrPMPEntries+1.
- Matching, with a = word address (32-bit unsigned) and p = pmpaddr[i]:
  - OFF: never matches.
  - NA4: a == p.
  - TOR: lo <= a < p, where lo = pmpaddr[i-1] for i > 0 (regardless of that entry's A field) and lo = 0 for i = 0. If lo >= p, no match.
  - NAPOT: mask = p ^ (p+1), 32-bit with wrap; match if (a & ~mask) == (p & ~mask). p = 0xFFFF_FFFF matches all addresses.
- Decision on match: if priv==3 and L==0, allow. Otherwise allow iff (req_access & ~cfg[2:0]) == 0. req_access==0 on match always allows.
- Decision on no match: allow iff priv==3.
- Entries at index >= NrPMPEntries never match, even if their cfg is nonzero.

Decomposition:
- pmp_pkg holds:
  - A-field encodings: PMP_OFF, PMP_TOR, PMP_NA4, PMP_NAPOT.
  - cfg bit positions: R, W, X, A_LO/A_HI, L.
  - privilege constants: PRIV_M=3, PRIV_S=1, PRIV_U=0.
  - FSM state encoding.
- Sub-module pmp_entry_match: combinational. Inputs are cfg byte, p, lo, and word address; output is match. Instantiated once and fed from the snapshot by idx.

Test Plan:
- Entry 0 cfg=0x1D (NAPOT, R|X), pmpaddr0=0x2000_01FF (4 KB at 0x8000_0000). U read 0x8000_0010 -> allow=1, match=1, idx=0, resp_valid in cycle 2. U write same address -> allow=0, match=1.
- Entry 0 cfg=0x00, pmpaddr0=0x2000_0000; entry 1 cfg=0x0B (TOR, R|W), pmpaddr1=0x2000_0400. U write 0x8000_0FFC -> allow=1, idx=1, cycle 3. U write 0x8000_1000 -> match=0, allow=0, cycle 9 (NrPMPEntries=8).
- Lock semantics: entry 0 cfg=0x99 (L, NAPOT, R), pmpaddr0=0xFFFF_FFFF. M write -> allow=0. With cfg=0x19 (no L), M write -> allow=1. With all cfg=0, M write -> match=0, allow=1 in cycle 9.
- Snapshot and backpressure: accept the TOR request, then zero pmpcfg_i in cycle 1. Response is still allow=1, idx=1. Hold resp_ready_i=0 for 5 cycles: outputs stable, req_ready_o=0. After the handshake, req_ready_o=1 next cycle.
- Inactive entries: cfg8=0x1F (NAPOT, RWX), pmpaddr8=0xFFFF_FFFF, entries 0-7 OFF. U read 0x0000_1000 -> match=0, allow=0.
- Reset mid-walk: assert rst_i in cycle 2 of a no-match walk. Outputs go to 0 immediately (async), no response appears, req_ready_o=1 after deassertion, and the next request completes normally.
